// File: rtl/simple_comparator_pkg.sv
// simple_comparator_pkg: shared compare result encoding and default operand width
package simple_comparator_pkg;

    typedef enum logic [1:0] {
        CMP_NONE,
        CMP_EQ,
        CMP_LT,
        CMP_GT
    } cmp_result_t;

    localparam int DEFAULT_WIDTH = 1;

endpackage

// File: rtl/simple_comparator_core.sv
// simple_comparator_core: combinational unsigned full-width ordering of a against b
module simple_comparator_core
    import simple_comparator_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output cmp_result_t      result
);

    assign result = (a == b) ? CMP_EQ : (a < b) ? CMP_LT : CMP_GT;

endmodule

// File: rtl/simple_comparator.sv
// simple_comparator: registered equal/less/greater compare; mismatch counter built only with SIMPLE_COMPARATOR_STATS_EN
module simple_comparator
    import simple_comparator_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] input_a,
    input  logic [WIDTH-1:0] input_b,
    output logic             out_valid,
    output logic             res,
    output logic             res_lt,
    output logic             res_gt,
    output logic [CNT_W-1:0] mismatch_cnt
);

    cmp_result_t cmp;

    simple_comparator_core #(.WIDTH(WIDTH)) u_core (
        .a     (input_a),
        .b     (input_b),
        .result(cmp)
    );

    // Capture one-hot flags on each accepted compare and hold them while idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            res       <= 1'b0;
            res_lt    <= 1'b0;
            res_gt    <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                res    <= cmp == CMP_EQ;
                res_lt <= cmp == CMP_LT;
                res_gt <= cmp == CMP_GT;
            end
        end
    end

`ifdef SIMPLE_COMPARATOR_STATS_EN
    // Saturating count of accepted compares whose operands differ
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            mismatch_cnt <= '0;
        else if (in_valid && cmp != CMP_EQ && mismatch_cnt != {CNT_W{1'b1}})
            mismatch_cnt <= mismatch_cnt + 1'b1;
    end
`else
    assign mismatch_cnt = '0;
`endif

endmodule

// File: tb/tb_simple_comparator.sv
// tb_simple_comparator: directed table-driven checks of WIDTH=1 and WIDTH=8 comparators
module tb_simple_comparator;

`ifdef SIMPLE_COMPARATOR_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    typedef struct {
        bit         rst;
        bit         v;
        logic [7:0] a;
        logic [7:0] b;
        bit         ov;
        bit         eq;
        bit         lt;
        bit         gt;
        int         cnt;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        v1 = 1'b0, a1 = 1'b0, b1 = 1'b0;
    logic        v8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        ov1, eq1, lt1, gt1, ov8, eq8, lt8, gt8;
    logic [15:0] cnt1;
    logic [1:0]  cnt8;
    int          checks = 0;
    int          errors = 0;
    vec_t        t1[4];
    vec_t        t8[12];

    always #5 clk = ~clk;

    simple_comparator #(.WIDTH(1), .CNT_W(16)) d1 (
        .clk(clk), .rst_n(rst_n), .in_valid(v1), .input_a(a1), .input_b(b1),
        .out_valid(ov1), .res(eq1), .res_lt(lt1), .res_gt(gt1), .mismatch_cnt(cnt1)
    );

    simple_comparator #(.WIDTH(8), .CNT_W(2)) d8 (
        .clk(clk), .rst_n(rst_n), .in_valid(v8), .input_a(a8), .input_b(b8),
        .out_valid(ov8), .res(eq8), .res_lt(lt8), .res_gt(gt8), .mismatch_cnt(cnt8)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".d1.out_valid"}, {31'd0, ov1}, 0);
        chk({tag, ".d1.res"}, {31'd0, eq1}, 0);
        chk({tag, ".d1.res_lt"}, {31'd0, lt1}, 0);
        chk({tag, ".d1.res_gt"}, {31'd0, gt1}, 0);
        chk({tag, ".d1.cnt"}, {16'd0, cnt1}, 0);
        chk({tag, ".d8.out_valid"}, {31'd0, ov8}, 0);
        chk({tag, ".d8.res"}, {31'd0, eq8}, 0);
        chk({tag, ".d8.res_lt"}, {31'd0, lt8}, 0);
        chk({tag, ".d8.res_gt"}, {31'd0, gt8}, 0);
        chk({tag, ".d8.cnt"}, {30'd0, cnt8}, 0);
    endtask

    task automatic run(input bit w8, input int idx, input vec_t t);
        string n;
        n = $sformatf("%s[%0d]", w8 ? "w8" : "w1", idx);
        if (t.rst) begin
            #2 rst_n = 1'b0;
            #1 chk_zero({n, ".midreset"});
            #1 rst_n = 1'b1;
        end
        if (w8) begin
            v8 = t.v; a8 = t.a; b8 = t.b;
        end else begin
            v1 = t.v; a1 = t.a[0]; b1 = t.b[0];
        end
        @(posedge clk);
        #1;
        chk({n, ".out_valid"}, {31'd0, w8 ? ov8 : ov1}, {31'd0, t.ov});
        chk({n, ".res"}, {31'd0, w8 ? eq8 : eq1}, {31'd0, t.eq});
        chk({n, ".res_lt"}, {31'd0, w8 ? lt8 : lt1}, {31'd0, t.lt});
        chk({n, ".res_gt"}, {31'd0, w8 ? gt8 : gt1}, {31'd0, t.gt});
        chk({n, ".cnt"}, w8 ? {30'd0, cnt8} : {16'd0, cnt1}, STATS ? t.cnt : 0);
    endtask

    initial begin
        //        rst v  a      b      ov eq lt gt cnt
        t1[0] = '{0, 1, 8'h00, 8'h00, 1, 1, 0, 0, 0};
        t1[1] = '{0, 1, 8'h00, 8'h01, 1, 0, 1, 0, 1};
        t1[2] = '{0, 1, 8'h01, 8'h00, 1, 0, 0, 1, 2};
        t1[3] = '{0, 1, 8'h01, 8'h01, 1, 1, 0, 0, 2};

        t8[0]  = '{0, 1, 8'hFF, 8'h00, 1, 0, 0, 1, 1};
        t8[1]  = '{0, 1, 8'h00, 8'hFF, 1, 0, 1, 0, 2};
        t8[2]  = '{0, 1, 8'hA5, 8'hA5, 1, 1, 0, 0, 2};
        t8[3]  = '{0, 1, 8'h03, 8'h03, 1, 1, 0, 0, 2};
        t8[4]  = '{0, 0, 8'h01, 8'h02, 0, 1, 0, 0, 2};
        t8[5]  = '{1, 1, 8'h10, 8'h20, 1, 0, 1, 0, 1};
        t8[6]  = '{0, 1, 8'h80, 8'h7F, 1, 0, 0, 1, 2};
        t8[7]  = '{0, 1, 8'h01, 8'h00, 1, 0, 0, 1, 3};
        t8[8]  = '{0, 1, 8'hFE, 8'hFF, 1, 0, 1, 0, 3};
        t8[9]  = '{0, 1, 8'h00, 8'h01, 1, 0, 1, 0, 3};
        t8[10] = '{0, 1, 8'h5A, 8'h5A, 1, 1, 0, 0, 3};
        t8[11] = '{0, 0, 8'h09, 8'h01, 0, 1, 0, 0, 3};

        // Reset held with toggling operands and valid asserted
        for (int i = 0; i < 3; i++) begin
            v1 = 1'b1; v8 = 1'b1; a1 = i[0]; b1 = ~i[0];
            a8 = 8'(i * 37); b8 = 8'(i * 91 + 5);
            @(posedge clk);
            #1 chk_zero($sformatf("reset%0d", i));
        end
        v1 = 1'b0; v8 = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            a1 = ~a1; a8 = a8 + 8'd3; b8 = b8 - 8'd7;
            @(posedge clk);
            #1 chk_zero($sformatf("idle%0d", i));
        end

        for (int i = 0; i < 4; i++) run(1'b0, i, t1[i]);
        v1 = 1'b0;
        for (int i = 0; i < 12; i++) run(1'b1, i, t8[i]);
        v8 = 1'b0;

        @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
